morse_code_matcher: RTL and testbench
=====================================

Name: morse_code_matcher

Overview:
- Parametrised successor to the player-2 guess checker in the Morse game.
- Compares a stream of decoded dot/line pulses, from the existing morse decoder, against a secret code of up to MAX_SYMBOLS symbols latched from player 1.
- Adds explicit rounds, a lives counter, an inter-symbol timeout, overflow and premature-done detection, and win/lose status.
- Sits between the morse decoder and the game-level display/score logic.

Parameters:
- MAX_SYMBOLS, 5, max code length in symbols; the secret and guess buses are 2*MAX_SYMBOLS bits wide.
- MAX_LIVES, 3, wrong attempts allowed per round (must be >= 1).
- TIMEOUT_CYCLES, 50000000, idle cycles in GUESS before a timeout counts as a miss; 0 disables the timeout.
- Derived: LW = $clog2(MAX_LIVES+1), PW = $clog2(MAX_SYMBOLS+1).

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches secret and begins a round.
- secret  in  2*MAX_SYMBOLS  player-1 code, left-aligned; symbol 0 is in the MSBs.
- ld_dot  in  1  one-cycle pulse from the decoder: dot entered.
- ld_line  in  1  one-cycle pulse from the decoder: line entered.
- done_input  in  1  one-cycle pulse: player 2 claims the entry is complete.
- correct  out  1  one-cycle pulse: last symbol matched.
- wrong  out  1  one-cycle pulse: miss (mismatch, overflow, premature done, timeout).
- complete  out  1  level; high in WIN.
- failed  out  1  level; high in LOSE.
- busy  out  1  level; high in GUESS.
- lives  out  LW  remaining lives.
- progress  out  PW  symbols matched so far in the current attempt.
- q  out  2*MAX_SYMBOLS  player-2 guess shift register; the newest symbol is in the LSBs.

Behaviour:
- Symbol encoding: NONE=00, DOT=01, LINE=11. 10 is reserved and treated as a terminator.
- Code length L = number of leading symbols before the first 00/10; it is computed when start is registered.
- Reset (resetn=0, async): state IDLE; correct=wrong=complete=failed=busy=0; progress=0; q=0; lives=MAX_LIVES; internal secret copy, length and timer cleared.
- All outputs are registered. Each response appears on the clock edge that samples the input (1-cycle latency).
- States: IDLE, GUESS, WIN, LOSE.
- start, in any state:
  - If L>0: load secret copy, lives=MAX_LIVES, progress=0, q=0, timer=0, go to GUESS.
  - If L=0: start is ignored and the state is unchanged.
  - start has priority over every other input in the same cycle.
- GUESS, symbol event (exactly one of ld_dot/ld_line high):
  - q <= {q[2*MAX_SYMBOLS-3:0], sym}; timer=0.
  - If progress<L and sym equals the secret symbol at index progress: progress++, pulse correct.
  - Otherwise (mismatch, or progress==L overflow): miss.
- ld_dot and ld_line both high in the same cycle: miss; q is unchanged.
- GUESS, done_input (with no symbol pulse that cycle):
  - If progress==L: go to WIN, complete=1.
  - Otherwise: miss.
- done_input in the same cycle as a symbol pulse: done_input is ignored.
- Miss: pulse wrong; lives--.
  - If lives becomes 0: go to LOSE, failed=1.
  - Otherwise stay in GUESS with progress=0, q=0, timer=0 (the attempt restarts from symbol 0).
- Timeout (TIMEOUT_CYCLES>0): the timer increments every GUESS cycle with no symbol or done event. When it reaches TIMEOUT_CYCLES-1, the next cycle is a miss.
- WIN/LOSE: hold all status; ignore ld_dot, ld_line and done_input; only start or reset leaves.
- IDLE: ignore ld_dot, ld_line and done_input.
- correct and wrong are never high together; each is high for exactly one cycle per event.
- Reset asserted mid-round returns to IDLE immediately, regardless of clock.

Test Plan (MAX_SYMBOLS=5, MAX_LIVES=3, TIMEOUT_CYCLES=8, secret=10'b01_11_01_00_00):
- start; dot, line, dot; done -> correct pulse x3, progress 1,2,3, q=10'b00_00_01_11_01; complete=1 the cycle after done; lives=3.
- start; dot, dot -> second dot gives wrong pulse, lives=2, progress=0, q=0; then dot, line, dot, done -> complete=1.
- start; three misses (dot, dot / line / line) -> lives 2,1,0; failed=1; busy=0; later ld_dot and done ignored; a new start -> GUESS, lives=3, failed=0.
- start; dot, line; done -> wrong (premature), lives=2. Then dot, line, dot, dot -> fourth symbol is overflow, wrong, lives=1.
- start; no input for 8 cycles -> wrong pulse, lives=2. Same case with a symbol every 5 cycles -> no timeout.
- Edge cases: start with secret=0 -> stays IDLE. ld_dot and ld_line together -> wrong. resetn low mid-round -> all outputs 0, lives=3, IDLE.

Source files
------------

// File: rtl/morse_code_matcher.sv
// morse_code_matcher
//   Checks player 2's stream of decoded dot/line pulses against a secret code
//   of up to MAX_SYMBOLS symbols latched from player 1. A round has a limited
//   number of lives, an inter-symbol timeout, and detection of overflow and
//   premature done. The round ends in a WIN or LOSE state.
//
//   Symbol encoding: NONE=00, DOT=01, LINE=11, 10 reserved (acts as terminator).
//
// Ports
//   clock       in   system clock, rising edge
//   resetn      in   asynchronous active-low reset
//   start       in   pulse: latch secret, begin a round (ignored if code empty)
//   secret      in   player-1 code, symbol 0 in the MSBs
//   ld_dot      in   pulse: dot entered
//   ld_line     in   pulse: line entered
//   done_input  in   pulse: player 2 claims entry complete
//   correct     out  pulse: symbol matched
//   wrong       out  pulse: miss (mismatch, overflow, premature done, timeout)
//   complete    out  level: WIN state
//   failed      out  level: LOSE state
//   busy        out  level: GUESS state
//   lives       out  remaining lives
//   progress    out  symbols matched in the current attempt
//   q           out  guess shift register, newest symbol in the LSBs
//
// Valid/ready: there is no back-pressure. Every input pulse is consumed on the
// clock edge that samples it, and the registered response is visible right
// after that same edge.
module morse_code_matcher #(
   parameter int MAX_SYMBOLS    = 5,
   parameter int MAX_LIVES      = 3,
   parameter int TIMEOUT_CYCLES = 50000000,
   localparam int LW = $clog2(MAX_LIVES + 1),
   localparam int PW = $clog2(MAX_SYMBOLS + 1),
   localparam int W  = 2 * MAX_SYMBOLS
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          start,
   input  logic [W-1:0]  secret,
   input  logic          ld_dot,
   input  logic          ld_line,
   input  logic          done_input,
   output logic          correct,
   output logic          wrong,
   output logic          complete,
   output logic          failed,
   output logic          busy,
   output logic [LW-1:0] lives,
   output logic [PW-1:0] progress,
   output logic [W-1:0]  q
);

   // The timer never exceeds TIMEOUT_CYCLES-1, so $clog2(TIMEOUT_CYCLES) bits are enough.
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, GUESS, WIN, LOSE} state_t;

   state_t         state_q, state_d;
   logic [LW-1:0]  lives_q, lives_d;
   logic [PW-1:0]  progress_q, progress_d;
   logic [PW-1:0]  len_q, len_d;
   logic [W-1:0]   q_q, q_d;
   logic [W-1:0]   secret_q, secret_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           correct_q, correct_d;
   logic           wrong_q, wrong_d;
   logic           complete_q, complete_d;
   logic           failed_q, failed_d;
   logic           busy_q, busy_d;

   logic [PW-1:0]  start_len;
   logic [1:0]     exp_sym;
   logic [1:0]     sym;
   logic           miss;

   // Code length = count of leading DOT/LINE symbols. It stops at the first NONE or reserved symbol.
   always_comb begin
      logic stop;
      logic [1:0] s;
      start_len = '0;
      stop      = 1'b0;
      for (int i = 0; i < MAX_SYMBOLS; i++) begin
         s = secret[2*(MAX_SYMBOLS-1-i) +: 2];
         if (!stop && s[0]) start_len = start_len + 1'b1;
         else stop = 1'b1;
      end
   end

   // Secret symbol at index progress_q. Zero when progress is past the end.
   always_comb begin
      exp_sym = 2'b00;
      for (int i = 0; i < MAX_SYMBOLS; i++) begin
         if (progress_q == PW'(i)) exp_sym = secret_q[2*(MAX_SYMBOLS-1-i) +: 2];
      end
   end

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      progress_d = progress_q;
      len_d      = len_q;
      q_d        = q_q;
      secret_d   = secret_q;
      timer_d    = timer_q;
      correct_d  = 1'b0;
      wrong_d    = 1'b0;
      miss       = 1'b0;
      sym        = ld_dot ? 2'b01 : 2'b11;

      if (start && (start_len != '0)) begin
         state_d    = GUESS;
         secret_d   = secret;
         len_d      = start_len;
         lives_d    = LW'(MAX_LIVES);
         progress_d = '0;
         q_d        = '0;
         timer_d    = '0;
      end else if (state_q == GUESS) begin
         if (ld_dot && ld_line) begin
            miss = 1'b1;
         end else if (ld_dot || ld_line) begin
            q_d     = {q_q[W-3:0], sym};
            timer_d = '0;
            if ((progress_q < len_q) && (sym == exp_sym)) begin
               progress_d = progress_q + 1'b1;
               correct_d  = 1'b1;
            end else begin
               miss = 1'b1;
            end
         end else if (done_input) begin
            timer_d = '0;
            if (progress_q == len_q) state_d = WIN;
            else                     miss    = 1'b1;
         end else if (TIMEOUT_CYCLES > 0) begin
            if (timer_q == TMAX) miss    = 1'b1;
            else                 timer_d = timer_q + 1'b1;
         end

         if (miss) begin
            wrong_d = 1'b1;
            lives_d = lives_q - 1'b1;
            if (lives_q == LW'(1)) begin
               state_d = LOSE;
            end else begin
               // The attempt restarts from symbol 0.
               progress_d = '0;
               q_d        = '0;
               timer_d    = '0;
            end
         end
      end

      complete_d = (state_d == WIN);
      failed_d   = (state_d == LOSE);
      busy_d     = (state_d == GUESS);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         lives_q    <= LW'(MAX_LIVES);
         progress_q <= '0;
         len_q      <= '0;
         q_q        <= '0;
         secret_q   <= '0;
         timer_q    <= '0;
         correct_q  <= 1'b0;
         wrong_q    <= 1'b0;
         complete_q <= 1'b0;
         failed_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lives_q    <= lives_d;
         progress_q <= progress_d;
         len_q      <= len_d;
         q_q        <= q_d;
         secret_q   <= secret_d;
         timer_q    <= timer_d;
         correct_q  <= correct_d;
         wrong_q    <= wrong_d;
         complete_q <= complete_d;
         failed_q   <= failed_d;
         busy_q     <= busy_d;
      end
   end

   assign correct  = correct_q;
   assign wrong    = wrong_q;
   assign complete = complete_q;
   assign failed   = failed_q;
   assign busy     = busy_q;
   assign lives    = lives_q;
   assign progress = progress_q;
   assign q        = q_q;

endmodule

// File: tb/tb_morse_code_matcher.sv
// Directed bench for morse_code_matcher (MAX_SYMBOLS=5, MAX_LIVES=3, TIMEOUT_CYCLES=8).
// Status vectors are packed as {correct, wrong, complete, failed, busy}.
module tb_morse_code_matcher;
   logic       clock;
   logic       resetn;
   logic       start;
   logic [9:0] secret;
   logic       ld_dot;
   logic       ld_line;
   logic       done_input;
   logic       correct;
   logic       wrong;
   logic       complete;
   logic       failed;
   logic       busy;
   logic [1:0] lives;
   logic [2:0] progress;
   logic [9:0] q;

   int checks;
   int errors;

   localparam logic [9:0] SECRET = 10'b01_11_01_00_00;

   morse_code_matcher #(
      .MAX_SYMBOLS(5), .MAX_LIVES(3), .TIMEOUT_CYCLES(8)
   ) dut (
      .clock(clock), .resetn(resetn), .start(start), .secret(secret),
      .ld_dot(ld_dot), .ld_line(ld_line), .done_input(done_input),
      .correct(correct), .wrong(wrong), .complete(complete), .failed(failed),
      .busy(busy), .lives(lives), .progress(progress), .q(q)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic apply_reset();
      resetn = 1'b0; start = 1'b0; ld_dot = 1'b0; ld_line = 1'b0; done_input = 1'b0;
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
   endtask

   // driver: hold inputs across one rising edge, sample at the following negedge
   task automatic step(input logic d, input logic l, input logic dn, input logic st);
      ld_dot = d; ld_line = l; done_input = dn; start = st;
      @(negedge clock);
      ld_dot = 1'b0; ld_line = 1'b0; done_input = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00000 || lives !== 2'd3 ||
          progress !== 3'd0 || q !== 10'd0) begin
         errors++;
         $display("FAIL reset: st=%b lives=%0d prog=%0d q=%b, want st=00000 lives=3 prog=0 q=0",
                  {correct, wrong, complete, failed, busy}, lives, progress, q);
      end
   endtask

   task automatic test_win();
      secret = SECRET;
      step(0, 0, 0, 1);
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00001 || lives !== 2'd3 || progress !== 3'd0) begin
         errors++; $display("FAIL win_start: st=%b lives=%0d prog=%0d want 00001/3/0",
                            {correct, wrong, complete, failed, busy}, lives, progress);
      end
      step(1, 0, 0, 0);
      checks++;
      if ({correct, wrong} !== 2'b10 || progress !== 3'd1 || q !== 10'b00_00_00_00_01) begin
         errors++; $display("FAIL win_dot1: cw=%b prog=%0d q=%b want 10/1/0000000001", {correct, wrong}, progress, q);
      end
      step(0, 1, 0, 0);
      checks++;
      if ({correct, wrong} !== 2'b10 || progress !== 3'd2 || q !== 10'b00_00_00_01_11) begin
         errors++; $display("FAIL win_line: cw=%b prog=%0d q=%b want 10/2/0000000111", {correct, wrong}, progress, q);
      end
      step(1, 0, 0, 0);
      checks++;
      if ({correct, wrong} !== 2'b10 || progress !== 3'd3 || q !== 10'b00_00_01_11_01) begin
         errors++; $display("FAIL win_dot2: cw=%b prog=%0d q=%b want 10/3/0000011101", {correct, wrong}, progress, q);
      end
      step(0, 0, 1, 0);
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00100 || lives !== 2'd3) begin
         errors++; $display("FAIL win_done: st=%b lives=%0d want 00100/3", {correct, wrong, complete, failed, busy}, lives);
      end
      step(1, 0, 0, 0);
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00100 || q !== 10'b00_00_01_11_01) begin
         errors++; $display("FAIL win_hold: st=%b q=%b want 00100/0000011101", {correct, wrong, complete, failed, busy}, q);
      end
   endtask

   task automatic test_miss_retry();
      secret = SECRET;
      step(0, 0, 0, 1);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      checks++;
      if ({correct, wrong, busy} !== 3'b011 || lives !== 2'd2 || progress !== 3'd0 || q !== 10'd0) begin
         errors++; $display("FAIL retry_miss: cwb=%b lives=%0d prog=%0d q=%b want 011/2/0/0",
                            {correct, wrong, busy}, lives, progress, q);
      end
      step(1, 0, 0, 0); step(0, 1, 0, 0); step(1, 0, 0, 0); step(0, 0, 1, 0);
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00100 || lives !== 2'd2) begin
         errors++; $display("FAIL retry_win: st=%b lives=%0d want 00100/2", {correct, wrong, complete, failed, busy}, lives);
      end
   endtask

   task automatic test_lose();
      secret = SECRET;
      step(0, 0, 0, 1);
      step(1, 0, 0, 0); step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      checks++;
      if ({wrong, busy} !== 2'b11 || lives !== 2'd1) begin
         errors++; $display("FAIL lose_second: wb=%b lives=%0d want 11/1", {wrong, busy}, lives);
      end
      step(0, 1, 0, 0);
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b01010 || lives !== 2'd0) begin
         errors++; $display("FAIL lose_third: st=%b lives=%0d want 01010/0", {correct, wrong, complete, failed, busy}, lives);
      end
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00010 || lives !== 2'd0) begin
         errors++; $display("FAIL lose_hold: st=%b lives=%0d want 00010/0", {correct, wrong, complete, failed, busy}, lives);
      end
      step(0, 0, 0, 1);
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00001 || lives !== 2'd3) begin
         errors++; $display("FAIL lose_restart: st=%b lives=%0d want 00001/3", {correct, wrong, complete, failed, busy}, lives);
      end
   endtask

   task automatic test_premature_overflow();
      secret = SECRET;
      step(0, 0, 0, 1);
      step(1, 0, 0, 0); step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      checks++;
      if ({correct, wrong, complete, busy} !== 4'b0101 || lives !== 2'd2 || progress !== 3'd0) begin
         errors++; $display("FAIL premature_done: cwkb=%b lives=%0d prog=%0d want 0101/2/0",
                            {correct, wrong, complete, busy}, lives, progress);
      end
      step(1, 0, 0, 0); step(0, 1, 0, 0); step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      checks++;
      if ({correct, wrong, busy} !== 3'b011 || lives !== 2'd1 || progress !== 3'd0) begin
         errors++; $display("FAIL overflow: cwb=%b lives=%0d prog=%0d want 011/1/0",
                            {correct, wrong, busy}, lives, progress);
      end
   endtask

   task automatic test_timeout();
      logic seen;
      secret = SECRET;
      step(0, 0, 0, 1);
      seen = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step(0, 0, 0, 0);
         seen = seen | wrong;
      end
      checks++;
      if (seen !== 1'b0 || lives !== 2'd3) begin
         errors++; $display("FAIL timeout_early: wrong_seen=%b lives=%0d want 0/3", seen, lives);
      end
      step(0, 0, 0, 0);
      checks++;
      if ({wrong, busy} !== 2'b11 || lives !== 2'd2) begin
         errors++; $display("FAIL timeout_miss: wb=%b lives=%0d want 11/2", {wrong, busy}, lives);
      end
      // symbols every 5 cycles keep the timer from expiring
      step(0, 0, 0, 1);
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            seen = seen | wrong;
         end
         step(k != 1, k == 1, 0, 0);
         seen = seen | wrong;
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0);
         seen = seen | wrong;
      end
      step(0, 0, 1, 0);
      checks++;
      if (seen !== 1'b0 || complete !== 1'b1 || lives !== 2'd3) begin
         errors++; $display("FAIL timeout_paced: wrong_seen=%b complete=%b lives=%0d want 0/1/3", seen, complete, lives);
      end
   endtask

   task automatic test_edges();
      apply_reset();
      secret = 10'd0;
      step(0, 0, 0, 1);
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00000 || lives !== 2'd3) begin
         errors++; $display("FAIL empty_start: st=%b lives=%0d want 00000/3", {correct, wrong, complete, failed, busy}, lives);
      end
      secret = 10'b10_01_01_00_00;
      step(0, 0, 0, 1);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reserved_start: busy=%b want 0", busy);
      end
      secret = SECRET;
      step(0, 0, 0, 1);
      step(1, 1, 0, 0);
      checks++;
      if ({correct, wrong, busy} !== 3'b011 || lives !== 2'd2 || q !== 10'd0) begin
         errors++; $display("FAIL both_symbols: cwb=%b lives=%0d q=%b want 011/2/0", {correct, wrong, busy}, lives, q);
      end
      step(1, 0, 1, 0);
      checks++;
      if ({correct, wrong, complete} !== 3'b100 || progress !== 3'd1) begin
         errors++; $display("FAIL done_with_symbol: cwk=%b prog=%0d want 100/1", {correct, wrong, complete}, progress);
      end
      secret = 10'd0;
      step(0, 0, 0, 1);
      checks++;
      if (busy !== 1'b1 || progress !== 3'd1 || lives !== 2'd2) begin
         errors++; $display("FAIL empty_start_midround: busy=%b prog=%0d lives=%0d want 1/1/2", busy, progress, lives);
      end
      secret = SECRET;
      step(0, 1, 0, 1);
      checks++;
      if ({correct, wrong, busy} !== 3'b001 || progress !== 3'd0 || lives !== 2'd3 || q !== 10'd0) begin
         errors++; $display("FAIL start_priority: cwb=%b prog=%0d lives=%0d q=%b want 001/0/3/0",
                            {correct, wrong, busy}, progress, lives, q);
      end
      step(1, 0, 0, 0);
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({correct, wrong, complete, failed, busy} !== 5'b00000 || lives !== 2'd3 ||
          progress !== 3'd0 || q !== 10'd0) begin
         errors++; $display("FAIL async_reset: st=%b lives=%0d prog=%0d q=%b want 00000/3/0/0",
                            {correct, wrong, complete, failed, busy}, lives, progress, q);
      end
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      secret = SECRET;
      test_reset();
      test_win();
      test_miss_retry();
      test_lose();
      test_premature_overflow();
      test_timeout();
      test_edges();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
